sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 150 +++++++++++++++
 tb/tb_sync_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and
// sticky error flags.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   wr_en     - write request
//   wr_data   - word to write (DATA_WIDTH)
//   rd_en     - read request
//   rd_data   - registered read word (DATA_WIDTH), held when no read accepted
//   rd_valid  - rd_data holds a word popped on the previous cycle
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - stored words, 0..DEPTH (ADDR_WIDTH+1)
//   overflow  - sticky: write requested while full
//   underflow - sticky: read requested while empty
//
// fifo_addr_gen: wrapping address counter, advances by one on inc.

module fifo_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

module sync_fifo #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Requests are masked while reset is held so nothing lands in storage.
  assign wr_acc = wr_en && !full  && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  fifo_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Storage is deliberately not reset; count == 0 hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q  || (wr_en && full);
    underflow_d = underflow_q || (rd_en && empty);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (rd_acc) rd_data_d = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Structural invariants; ignored by synthesis.
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_q <= FULL_CNT);
  a_not_full_empty: assert property (@(posedge clk) disable iff (rst)
    !(full && empty));
  a_ptr_diff: assert property (@(posedge clk) disable iff (rst)
    full || (count_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(wr_ptr - rd_ptr)));
  a_valid_past: assert property (@(posedge clk) disable iff (rst)
    rd_valid_q |-> $past(rd_acc));

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized checks of sync_fifo (DEPTH 16)
// against a queue-based reference model.

module tb_sync_fifo;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".rd_valid"},  32'(rd_valid),  32'(m_valid));
    check({tag, ".rd_data"},   32'(rd_data),   32'(m_data));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // One clock cycle with the given requests; model advanced from pre-edge state.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic was_full, was_empty;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (w && was_full)  m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    m_valid = r && !was_empty;
    if (m_valid) m_data = q.pop_front();
    if (w && !was_full) q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0x01..0x10, then one write too many
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    check_all("fill");
    check("fill.full_const", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0);
    check_all("overflow");
    check("overflow.count16", 32'(count), 32'd16);

    // Full with both requests: read only
    step(1'b1, 8'hBB, 1'b1);
    check_all("full_both");
    step(1'b1, 8'h10, 1'b0);  // refill with same last value ordering preserved
    check_all("refill");

    // Drain all, checking each word
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      check_all("drain");
    end
    check("drain.empty", 32'(empty), 32'd1);

    // Read while empty
    step(1'b0, '0, 1'b1);
    check_all("underflow");
    check("underflow.valid0", 32'(rd_valid), 32'd0);

    // Empty with both requests: write only
    step(1'b1, 8'h5A, 1'b1);
    check_all("empty_both");

    // Bring to count 5, then stream 40 words with simultaneous write/read
    while (q.size() < 5) step(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), 1'b1);
      check_all("stream");
    end
    check("stream.count5", 32'(count), 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      check_all("random");
    end

    // Bring to count 7, then asynchronous reset mid-cycle
    while (q.size() > 7) step(1'b0, '0, 1'b1);
    while (q.size() < 7) step(1'b1, DW'($urandom), 1'b0);
    check("pre_rst.count7", 32'(count), 32'd7);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    // Requests during reset are ignored
    wr_en   = 1'b1;
    wr_data = 8'h77;
    rd_en   = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_held");
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hC3, 1'b0);
    check_all("post_rst_wr");
    step(1'b0, '0, 1'b1);
    check_all("post_rst_rd");
    check("post_rst_rd.data", 32'(rd_data), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
